// File: rtl/qbu_verify_ctrl_pkg.sv
// Shared types and constants for the Qbu preemption verification controller.
package qbu_verify_pkg;

  // Verification FSM states; encodings are visible on o_verify_state.
  typedef enum logic [2:0] {
    ST_DISABLED = 3'd0,
    ST_INIT     = 3'd1,
    ST_IDLE     = 3'd2,
    ST_SEND     = 3'd3,
    ST_WAIT     = 3'd4,
    ST_VERIFIED = 3'd5,
    ST_FAILED   = 3'd6
  } verify_state_e;

  localparam int unsigned VERIFY_TIMER_MIN = 1;
  localparam int unsigned VERIFY_TIMER_MAX = 128;
  localparam int unsigned ERR_CNT_W        = 16;

  // Maps the register timer value into the legal 1..128 ms window.
  function automatic logic [7:0] clamp_timer(input logic [7:0] t);
    if (t < 8'(VERIFY_TIMER_MIN)) return 8'(VERIFY_TIMER_MIN);
    if (t > 8'(VERIFY_TIMER_MAX)) return 8'(VERIFY_TIMER_MAX);
    return t;
  endfunction

endpackage

// File: rtl/qbu_verify_ctrl_if.sv
// mPacket request/ack and receive-event signals between the controller and the TX/RX MAC.
interface qbu_verify_ctrl_if;
  logic tx_verify_req;
  logic tx_verify_ack;
  logic tx_respond_req;
  logic tx_respond_ack;
  logic rx_verify;
  logic rx_respond;

  // Controller side.
  modport master (
    output tx_verify_req, tx_respond_req,
    input  tx_verify_ack, tx_respond_ack, rx_verify, rx_respond
  );

  // MAC side.
  modport slave (
    input  tx_verify_req, tx_respond_req,
    output tx_verify_ack, tx_respond_ack, rx_verify, rx_respond
  );
endinterface

// File: rtl/qbu_verify_ctrl_ms_timer.sv
// Verify timeout timer: a cycle prescaler producing ms ticks and an 8-bit ms down-counter.
// expire is high during the final tick, so a consumer registering on it acts exactly
// load_val * TICKS_PER_MS cycles after the load edge.
module qbu_ms_timer #(
  parameter int TICKS_PER_MS = 125000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       expire
);

  localparam int PRE_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;

  logic [PRE_W-1:0] pre_q;
  logic [7:0]       ms_q;
  logic             tick;

  assign tick   = (pre_q == PRE_W'(TICKS_PER_MS - 1));
  assign expire = tick && (ms_q == 8'd1);

  // Prescaler and ms counter; idle once the count reaches zero.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (i_rst) begin
      pre_q <= '0;
      ms_q  <= '0;
    end else if (load) begin
      pre_q <= '0;
      ms_q  <= load_val;
    end else if (ms_q != 8'd0) begin
      if (tick) begin
        pre_q <= '0;
        ms_q  <= ms_q - 8'd1;
      end else begin
        pre_q <= pre_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/qbu_verify_ctrl.sv
// IEEE 802.3br preemption verification sequencer for one Qbu TX/RX port pair,
// plus the independent respond-mPacket responder.
module qbu_verify_ctrl
  import qbu_verify_pkg::*;
#(
  parameter int TICKS_PER_MS = 125000,
  parameter int VERIFY_LIMIT = 3,
  parameter int AUTO_START   = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_reset,
  input  logic                 i_verify_enabled,
  input  logic [7:0]           i_verify_timer,
  input  logic                 i_start_verify,
  input  logic                 i_clear_verify,
  input  logic                 i_link_up,
  qbu_verify_ctrl_if.master    mac,
  output logic                 o_preempt_enable,
  output logic [2:0]           o_verify_state,
  output logic [ERR_CNT_W-1:0] o_err_verify_cnt
);

  logic                 rst;
  verify_state_e        state_q, state_d;
  logic [2:0]           attempt_q;
  logic [ERR_CNT_W-1:0] err_q;
  logic                 take_ack, take_expire, clr_err;
  logic                 expire;
  logic [7:0]           timer_load_val;
  logic                 preempt_d, preempt_q;
  logic                 verify_req_d, verify_req_q;
  logic                 pending_q;

  // The register-block soft reset behaves exactly like the hard reset.
  assign rst            = i_rst | i_reset;
  assign timer_load_val = clamp_timer(i_verify_timer);

  qbu_ms_timer #(
    .TICKS_PER_MS(TICKS_PER_MS)
  ) u_ms_timer (
    .i_clk    (i_clk),
    .i_rst    (rst),
    .load     (take_ack),
    .load_val (timer_load_val),
    .expire   (expire)
  );

  // Next-state logic: global overrides first, then per-state rules.
  // DISABLED only leaves once enabled and link are both up, so link/start/clear overrides skip it.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d     = state_q;
    take_ack    = 1'b0;
    take_expire = 1'b0;
    clr_err     = 1'b0;
    if (!i_verify_enabled) begin
      state_d = ST_DISABLED;
    end else if (state_q == ST_DISABLED) begin
      if (i_link_up) state_d = ST_INIT;
    end else if (!i_link_up) begin
      state_d = ST_INIT;
    end else if (i_clear_verify) begin
      state_d = ST_INIT;
      clr_err = 1'b1;
    end else if (i_start_verify) begin
      state_d = (state_q == ST_IDLE) ? ST_SEND : ST_INIT;
    end else begin
      unique case (state_q)
        ST_INIT: state_d = ST_IDLE;
        ST_IDLE: if (AUTO_START != 0) state_d = ST_SEND;
        ST_SEND: begin
          if (mac.tx_verify_ack) begin
            take_ack = 1'b1;
            state_d  = ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A response in the expiry cycle wins and suppresses the error count.
          if (mac.rx_respond) begin
            state_d = ST_VERIFIED;
          end else if (expire) begin
            take_expire = 1'b1;
            state_d     = (attempt_q < 3'(VERIFY_LIMIT)) ? ST_SEND : ST_FAILED;
          end
        end
        ST_VERIFIED, ST_FAILED: state_d = state_q;
        default: state_d = ST_DISABLED;
      endcase
    end
  end

  // Output decode from the next state, so the registered outputs line up with the state.
  always_comb begin
    preempt_d    = 1'b0;
    verify_req_d = 1'b0;
    unique case (state_d)
      ST_DISABLED: preempt_d    = i_link_up;
      ST_VERIFIED: preempt_d    = 1'b1;
      ST_SEND:     verify_req_d = 1'b1;
      default:     ;
    endcase
  end

  // State register and registered FSM outputs.
  always_ff @(posedge i_clk) begin
    if (rst) begin
      state_q      <= ST_DISABLED;
      preempt_q    <= 1'b0;
      verify_req_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      preempt_q    <= preempt_d;
      verify_req_q <= verify_req_d;
    end
  end

  // Attempt counter and saturating verify-timeout error counter.
  always_ff @(posedge i_clk) begin
    if (rst) begin
      attempt_q <= '0;
      err_q     <= '0;
    end else begin
      if (state_q == ST_INIT)  attempt_q <= '0;
      else if (take_ack)       attempt_q <= attempt_q + 3'd1;
      if (clr_err)                        err_q <= '0;
      else if (take_expire && err_q != '1) err_q <= err_q + 1'b1;
    end
  end

  // Responder: one pending respond request; a verify in the ack cycle re-arms it.
  always_ff @(posedge i_clk) begin
    if (rst) pending_q <= 1'b0;
    else     pending_q <= i_link_up & (mac.rx_verify | (pending_q & ~mac.tx_respond_ack));
  end

  assign mac.tx_verify_req  = verify_req_q;
  assign mac.tx_respond_req = pending_q;
  assign o_preempt_enable   = preempt_q;
  assign o_verify_state     = state_q;
  assign o_err_verify_cnt   = err_q;

endmodule

// File: tb/tb_qbu_verify_ctrl.sv
// Bench for qbu_verify_ctrl: directed scenarios with literal expectations plus random
// stimulus, all cross-checked every cycle against a deadline-based behavioural model.
module tb_qbu_verify_ctrl;

  localparam int TICKS = 4;
  localparam int LIMIT = 3;
  localparam int AUTO  = 1;

  localparam int S_DIS = 0, S_INIT = 1, S_IDLE = 2, S_SEND = 3,
                 S_WAIT = 4, S_VER = 5, S_FAIL = 6;

  logic        clk = 1'b0;
  logic        rst, soft_rst, ven, start, clear, link;
  logic [7:0]  vtimer;
  logic        preempt;
  logic [2:0]  vstate;
  logic [15:0] err;

  qbu_verify_ctrl_if mac();

  qbu_verify_ctrl #(
    .TICKS_PER_MS(TICKS),
    .VERIFY_LIMIT(LIMIT),
    .AUTO_START  (AUTO)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_reset          (soft_rst),
    .i_verify_enabled (ven),
    .i_verify_timer   (vtimer),
    .i_start_verify   (start),
    .i_clear_verify   (clear),
    .i_link_up        (link),
    .mac              (mac),
    .o_preempt_enable (preempt),
    .o_verify_state   (vstate),
    .o_err_verify_cnt (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 0;
  bit auto_vack;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_state = S_DIS, m_att = 0, m_err = 0, m_deadline = 0, m_cyc = 0;
  bit m_pend = 0, m_vreq = 0, m_pre = 0;

  function automatic int eff_timer(input int t);
    if (t == 0)  return 1;
    if (t > 128) return 128;
    return t;
  endfunction

  always @(posedge clk) begin : model
    int ns;
    m_cyc++;
    if (rst || soft_rst) begin
      m_state = S_DIS; m_att = 0; m_err = 0;
      m_pend = 0; m_vreq = 0; m_pre = 0;
    end else begin
      m_pend = link && (mac.rx_verify || (m_pend && !mac.tx_respond_ack));
      ns = m_state;
      if (!ven)                 ns = S_DIS;
      else if (m_state == S_DIS) ns = link ? S_INIT : S_DIS;
      else if (!link)           ns = S_INIT;
      else if (clear) begin     ns = S_INIT; m_err = 0; end
      else if (start)           ns = (m_state == S_IDLE) ? S_SEND : S_INIT;
      else begin
        case (m_state)
          S_INIT: ns = S_IDLE;
          S_IDLE: if (AUTO != 0) ns = S_SEND;
          S_SEND: if (mac.tx_verify_ack) begin
            m_att++;
            m_deadline = m_cyc + eff_timer(int'(vtimer)) * TICKS;
            ns = S_WAIT;
          end
          S_WAIT: if (mac.rx_respond) ns = S_VER;
            else if (m_cyc == m_deadline) begin
              if (m_err < 65535) m_err++;
              ns = (m_att < LIMIT) ? S_SEND : S_FAIL;
            end
          default: ;
        endcase
      end
      if (m_state == S_INIT) m_att = 0;
      m_state = ns;
      m_vreq  = (ns == S_SEND);
      m_pre   = (ns == S_VER) || (ns == S_DIS && link);
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_state",   32'(vstate),             32'(m_state));
      check("model_preempt", 32'(preempt),            32'(m_pre));
      check("model_vreq",    32'(mac.tx_verify_req),  32'(m_vreq));
      check("model_rreq",    32'(mac.tx_respond_req), 32'(m_pend));
      check("model_err",     32'(err),                32'(m_err));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
    if (auto_vack) mac.tx_verify_ack = mac.tx_verify_req;
  endtask

  task automatic pulse_start();
    start = 1; step(); start = 0;
  endtask

  task automatic pulse_clear();
    clear = 1; step(); clear = 0;
  endtask

  task automatic wait_state(input int s, input int budget, input string name);
    int n = 0;
    while (int'(vstate) != s && n < budget) begin step(); n++; end
    check(name, 32'(vstate), 32'(s));
  endtask

  // Cycles from the WAIT entry edge to the edge that leaves WAIT.
  task automatic measure(output int cyc);
    int n = 0;
    while (!mac.tx_verify_req && n < 20) begin step(); n++; end
    step();
    cyc = 0;
    while (int'(vstate) == S_WAIT && cyc < 700) begin step(); cyc++; end
  endtask

  initial begin
    int rise_t[$];
    int t, cyc;
    bit prev;
    rst = 1; soft_rst = 0; ven = 0; start = 0; clear = 0; link = 0; vtimer = 8'd10;
    mac.tx_verify_ack = 0; mac.tx_respond_ack = 0; mac.rx_verify = 0; mac.rx_respond = 0;
    auto_vack = 1;
    @(posedge clk);
    cmp_en = 1;
    step(); step();
    check("rst_state",   32'(vstate), 0);
    check("rst_preempt", 32'(preempt), 0);
    check("rst_err",     32'(err), 0);
    check("rst_vreq",    32'(mac.tx_verify_req), 0);

    // Scenario 1: bring-up latency and a successful verify.
    rst = 0; ven = 1; link = 0;
    step(); step();
    check("dis_hold", 32'(vstate), S_DIS);
    link = 1;
    step(); check("lat_init", 32'(vstate), S_INIT);
    step(); check("lat_idle", 32'(vstate), S_IDLE);
    step(); check("lat_send", 32'(vstate), S_SEND);
    check("vreq_up", 32'(mac.tx_verify_req), 1);
    step(); check("wait_entry", 32'(vstate), S_WAIT);
    check("vreq_drop", 32'(mac.tx_verify_req), 0);
    repeat (4) step();
    mac.rx_respond = 1; step(); mac.rx_respond = 0;
    check("s1_state",   32'(vstate), S_VER);
    check("s1_preempt", 32'(preempt), 1);
    check("s1_err",     32'(err), 0);

    // Scenario 2: no response, timer 2 ms -> three requests, then FAILED.
    vtimer = 8'd2;
    pulse_start();
    prev = 0; t = 0;
    while (int'(vstate) != S_FAIL && t < 100) begin
      step(); t++;
      if (mac.tx_verify_req && !prev) rise_t.push_back(t);
      prev = mac.tx_verify_req;
    end
    check("s2_nreq", 32'(rise_t.size()), 3);
    if (rise_t.size() == 3) begin
      check("s2_gap1", 32'(rise_t[1] - rise_t[0]), 9);
      check("s2_gap2", 32'(rise_t[2] - rise_t[1]), 9);
    end
    check("s2_err",     32'(err), 3);
    check("s2_state",   32'(vstate), S_FAIL);
    check("s2_preempt", 32'(preempt), 0);

    // Scenario 3: response in the expiry cycle.
    pulse_start();
    t = 0;
    while (!mac.tx_verify_req && t < 10) begin step(); t++; end
    repeat (8) step();
    mac.rx_respond = 1; step(); mac.rx_respond = 0;
    check("s3_state", 32'(vstate), S_VER);
    check("s3_err",   32'(err), 3);

    // Scenario 4: timer clamping.
    vtimer = 8'd0;   pulse_start(); measure(cyc); check("timeout_t0",   32'(cyc), 4);
    vtimer = 8'd200; pulse_start(); measure(cyc); check("timeout_t200", 32'(cyc), 512);

    // Scenario 5: exits from FAILED.
    vtimer = 8'd1;
    pulse_clear();
    wait_state(S_FAIL, 200, "s5_failed_a");
    check("s5_err_a", 32'(err), 3);
    pulse_clear();
    check("clr_state", 32'(vstate), S_INIT);
    check("clr_err",   32'(err), 0);
    wait_state(S_FAIL, 200, "s5_failed_b");
    pulse_start();
    check("start_state", 32'(vstate), S_INIT);
    check("start_err",   32'(err), 3);
    wait_state(S_FAIL, 200, "s5_failed_c");
    link = 0; step();
    check("linkdn_state", 32'(vstate), S_INIT);
    link = 1; ven = 0; step();
    check("dis_state",  32'(vstate), S_DIS);
    check("dis_pre_up", 32'(preempt), 1);
    link = 0; step();
    check("dis_pre_dn", 32'(preempt), 0);

    // Scenario 6: responder merge/re-arm, then reset mid-SEND with a late ack.
    auto_vack = 0; mac.tx_verify_ack = 0;
    ven = 1; link = 1;
    mac.rx_verify = 1; step(); mac.rx_verify = 0;
    check("rsp_up", 32'(mac.tx_respond_req), 1);
    step(); mac.rx_verify = 1; step(); mac.rx_verify = 0;
    check("rsp_merge", 32'(mac.tx_respond_req), 1);
    step(); check("rsp_hold", 32'(mac.tx_respond_req), 1);
    mac.tx_respond_ack = 1; step(); mac.tx_respond_ack = 0;
    check("rsp_drop", 32'(mac.tx_respond_req), 0);
    mac.rx_verify = 1; step();
    mac.tx_respond_ack = 1; step(); mac.rx_verify = 0; mac.tx_respond_ack = 0;
    check("rsp_rearm", 32'(mac.tx_respond_req), 1);
    mac.tx_respond_ack = 1; step(); mac.tx_respond_ack = 0;
    check("rsp_rearm_drop", 32'(mac.tx_respond_req), 0);
    check("held_send", 32'(vstate), S_SEND);
    mac.rx_verify = 1; step(); mac.rx_verify = 0;
    rst = 1; step();
    check("mrst_state", 32'(vstate), 0);
    check("mrst_pre",   32'(preempt), 0);
    check("mrst_vreq",  32'(mac.tx_verify_req), 0);
    check("mrst_rreq",  32'(mac.tx_respond_req), 0);
    check("mrst_err",   32'(err), 0);
    rst = 0; mac.tx_verify_ack = 1; step(); mac.tx_verify_ack = 0;
    check("late_ack_state", 32'(vstate), S_INIT);

    // Random phase: model comparison every cycle.
    for (int i = 0; i < 4000; i++) begin
      step();
      mac.tx_verify_ack  = ($urandom_range(0, 2) != 0);
      mac.tx_respond_ack = ($urandom_range(0, 2) == 0);
      mac.rx_verify      = ($urandom_range(0, 5) == 0);
      mac.rx_respond     = ($urandom_range(0, 15) == 0);
      start              = ($urandom_range(0, 63) == 0);
      clear              = ($urandom_range(0, 79) == 0);
      soft_rst           = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 119) == 0) link = ~link;
      if ($urandom_range(0, 399) == 0) ven = ~ven;
      if ($urandom_range(0, 49) == 0) begin
        case ($urandom_range(0, 5))
          0: vtimer = 8'd0;
          1: vtimer = 8'd200;
          default: vtimer = 8'($urandom_range(1, 3));
        endcase
      end
    end
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/qbu_verify_ctrl.md
# qbu_verify_ctrl

Sequences the IEEE 802.3br preemption verification handshake for one Qbu TX/RX port pair. Configuration comes from the Qbu register block: verify enable, verify timer, and the start/clear verify pulses. The block drives verify and respond mPacket requests into the TX MAC and returns preempt-enable and verify-error status to the register block.

## Interface
- TICKS_PER_MS, 125000, i_clk cycles per 1 ms verify-timer tick (benches override small).
- VERIFY_LIMIT, 3, number of verify mPackets sent before declaring failure (1..7).
- AUTO_START, 1, 1 = INIT proceeds to SEND without waiting for i_start_verify.
- i_clk  in  1  single clock domain.
- i_rst  in  1  synchronous, active-high reset.
- i_reset  in  1  soft-reset pulse from register 0x0E; same effect as i_rst.
- i_verify_enabled  in  1  level; 0 disables verification (register 0x01).
- i_verify_timer  in  8  timeout in ms; 0 is treated as 1, values >128 clamp to 128.
- i_start_verify  in  1  pulse; restarts verification.
- i_clear_verify  in  1  pulse; restarts verification and clears the error counter.
- i_link_up  in  1  PHY link level.
- i_rx_verify  in  1  pulse; a verify mPacket was received.
- i_rx_respond  in  1  pulse; a respond mPacket was received.
- o_tx_verify_req / i_tx_verify_ack  out/in  1/1  request/ack pair for sending a verify mPacket.
- o_tx_respond_req / i_tx_respond_ack  out/in  1/1  request/ack pair for sending a respond mPacket.
- o_preempt_enable  out  1  preemption permitted (feeds register 0x00).
- o_verify_state  out  3  current FSM state encoding.
- o_err_verify_cnt  out  16  verify timeouts, saturating (feeds register 0x0A).

## Operation
- States and encodings: DISABLED=0, INIT=1, IDLE=2, SEND=3, WAIT=4, VERIFIED=5, FAILED=6.
- Global transitions, highest priority first, evaluated every cycle:
  - i_rst or i_reset: DISABLED; all registers cleared.
  - !i_verify_enabled: DISABLED.
  - !i_link_up: INIT.
  - i_clear_verify: INIT; o_err_verify_cnt cleared.
  - i_start_verify (from any state except DISABLED): INIT.
- DISABLED: o_preempt_enable = i_link_up. Moves to INIT when i_verify_enabled and i_link_up are both high.
- INIT: clears the attempt counter. Moves to IDLE on the next cycle while link is up.
- IDLE: moves to SEND when AUTO_START=1. When AUTO_START=0, waits for i_start_verify.
  - i_start_verify in IDLE goes directly to SEND, overriding the global INIT rule.
- SEND: o_tx_verify_req is held high until i_tx_verify_ack. The request is registered.
  - On the ack cycle: increment the attempt counter, load the ms timer from the clamped i_verify_timer value, go to WAIT.
  - o_tx_verify_req drops on the cycle after the ack.
- WAIT:
  - i_rx_respond: VERIFIED.
  - Timer expiry: increment o_err_verify_cnt (saturating at 0xFFFF). Then go to SEND if attempts < VERIFY_LIMIT, else FAILED.
  - i_rx_respond and expiry in the same cycle: VERIFIED wins, and the error counter is not incremented.
- VERIFIED: o_preempt_enable = 1. Absorbing until a global transition occurs.
- FAILED: o_preempt_enable = 0. Absorbing until a global transition occurs.
- In all other states o_preempt_enable = 0.
- i_rx_respond outside WAIT is ignored.
- Responder runs independently of the FSM:
  - i_rx_verify while i_link_up sets a pending flag, which drives o_tx_respond_req.
  - Further i_rx_verify pulses while pending merge into the one request.
  - Pending clears on i_tx_respond_ack, on link down, or on reset.
  - An i_rx_verify arriving in the same cycle as the ack re-arms the flag.
- Both TX requests may be high together; the TX MAC arbitrates. The two acks are independent.

## Timing
- Reset value of every output is 0; state resets to DISABLED.
- All outputs are registered. Input events take effect at the next clock edge.
- Entering WAIT resets the prescaler and loads ms_cnt = T.
  - A ms tick fires every TICKS_PER_MS cycles; each tick decrements ms_cnt.
  - Expiry is the tick at which ms_cnt == 1, i.e. exactly T*TICKS_PER_MS cycles after the WAIT entry edge.
- i_verify_timer is sampled only at the SEND ack. Changes during WAIT do not affect the running timer.
- Minimum latencies:
  - Link-up with verify enabled to the first o_tx_verify_req: 3 cycles (DISABLED→INIT→IDLE→SEND).
  - i_rx_respond in WAIT to o_preempt_enable: 1 cycle.
  - i_rx_verify to o_tx_respond_req: 1 cycle.
- Reset or link loss mid-handshake drops o_tx_verify_req the next cycle; a late ack is ignored.

## Structure
- Package qbu_verify_pkg holds:
  - the state typedef and encodings;
  - the clamp constants VERIFY_TIMER_MIN=1 and VERIFY_TIMER_MAX=128;
  - the counter width (16).
- Sub-module qbu_ms_timer holds the prescaler plus the 8-bit ms down-counter, with ports load, load_val, expire.

## Test plan
All scenarios use TICKS_PER_MS=4, VERIFY_LIMIT=3, AUTO_START=1.
- Link up, verify enabled, TX ack same cycle, i_rx_respond 5 cycles later -> sequence 0→1→2→3→4→5, then o_preempt_enable=1, o_err_verify_cnt=0.
- i_verify_timer=2, no response -> three verify requests spaced 8 cycles after each ack, o_err_verify_cnt=3, state FAILED=6, o_preempt_enable=0.
- Response and expiry in the same cycle -> VERIFIED, o_err_verify_cnt unchanged.
- i_verify_timer=0 -> timeout after 4 cycles; i_verify_timer=200 -> timeout after 512 cycles.
- In FAILED with o_err_verify_cnt=3: i_clear_verify -> counter 0 and state INIT; i_start_verify -> state INIT, counter stays 3; link down -> INIT; i_verify_enabled=0 -> DISABLED, with o_preempt_enable tracking i_link_up.
- Two i_rx_verify pulses with ack withheld -> a single o_tx_respond_req that holds until ack and drops the next cycle. i_rst asserted mid-SEND -> all outputs 0 on the next cycle.
